// File: rtl/ex_stage.sv
// MIPS32 execute stage: forwarding operand muxes, single-cycle ALU, a 4-step
// iterative multiply that stalls upstream, and the EX/MEM pipeline register.
module ex_stage #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             id_valid,
    input  logic [WIDTH-1:0] id_rs_val,
    input  logic [WIDTH-1:0] id_rt_val,
    input  logic [WIDTH-1:0] id_imm,
    input  logic [4:0]       id_shamt,
    input  logic             id_alusrc,
    input  logic [3:0]       id_aluop,
    input  logic             id_regwrite,
    input  logic             id_memread,
    input  logic             id_memwrite,
    input  logic             id_memtoreg,
    input  logic [4:0]       id_rd,
    input  logic [1:0]       FwdA,
    input  logic [1:0]       FwdB,
    input  logic             FwdM,
    input  logic [WIDTH-1:0] memwb_data,
    input  logic             ex_flush,
    output logic             ex_stall,
    output logic [WIDTH-1:0] exmem_alu,
    output logic [WIDTH-1:0] exmem_store,
    output logic [4:0]       exmem_rd,
    output logic             exmem_regwrite,
    output logic             exmem_memread,
    output logic             exmem_memwrite,
    output logic             exmem_memtoreg
);

    localparam int SW = WIDTH / 4;
    localparam logic [3:0] OP_MUL = 4'b1011;

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state_q, state_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d, acc_q, acc_d;
    logic [3:0]       mctl_q, mctl_d;
    logic [4:0]       mrd_q, mrd_d;

    logic [WIDTH-1:0] alu_q, alu_d, store_q, store_d;
    logic [4:0]       rd_q, rd_d;
    logic [3:0]       ctl_q, ctl_d;

    logic [WIDTH-1:0] op_a, raw_b, op_b, store_val, alu_res;
    logic [WIDTH-1:0] b_shr, partial, acc_sum;
    logic [SW-1:0]    b_slice;
    logic             is_mul, slt;

    always_comb begin
        case (FwdA)
            2'b00:   op_a = id_rs_val;
            2'b01:   op_a = memwb_data;
            default: op_a = exmem_alu;
        endcase
        case (FwdB)
            2'b00:   raw_b = id_rt_val;
            2'b01:   raw_b = memwb_data;
            default: raw_b = exmem_alu;
        endcase
        op_b      = id_alusrc ? id_imm : raw_b;
        store_val = FwdM ? exmem_alu : raw_b;
    end

    always_comb begin
        slt = $signed(op_a) < $signed(op_b);
        case (id_aluop)
            4'b0000: alu_res = op_a + op_b;
            4'b0001: alu_res = op_a - op_b;
            4'b0010: alu_res = op_a & op_b;
            4'b0011: alu_res = op_a | op_b;
            4'b0100: alu_res = op_a ^ op_b;
            4'b0101: alu_res = ~(op_a | op_b);
            4'b0110: alu_res = {{(WIDTH-1){1'b0}}, slt};
            4'b0111: alu_res = op_b << id_shamt;
            4'b1000: alu_res = op_b >> id_shamt;
            4'b1001: alu_res = $signed(op_b) >>> id_shamt;
            4'b1010: alu_res = op_b << 16;
            default: alu_res = '0;
        endcase
    end

    // One multiplier slice per step, weighted by its position in B.
    always_comb begin
        b_shr   = b_q >> (32'(cnt_q) * SW);
        b_slice = b_shr[SW-1:0];
        partial = (a_q * {{(WIDTH-SW){1'b0}}, b_slice}) << (32'(cnt_q) * SW);
        acc_sum = acc_q + partial;
    end

    assign is_mul   = id_valid && (id_aluop == OP_MUL);
    assign ex_stall = rst_n && !ex_flush &&
                      ((state_q == BUSY) ? (cnt_q != 2'd3) : is_mul);

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        acc_d   = acc_q;
        mctl_d  = mctl_q;
        mrd_d   = mrd_q;
        alu_d   = '0;
        store_d = '0;
        rd_d    = '0;
        ctl_d   = '0;
        if (ex_flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            acc_d   = '0;
        end else if (state_q == BUSY) begin
            acc_d = acc_sum;
            if (cnt_q == 2'd3) begin
                state_d = IDLE;
                cnt_d   = '0;
                alu_d   = acc_sum;
                rd_d    = mrd_q;
                ctl_d   = mctl_q;
            end else begin
                cnt_d = cnt_q + 2'd1;
            end
        end else if (is_mul) begin
            // Forwarded sources move during the stall, so capture them now.
            state_d = BUSY;
            cnt_d   = '0;
            a_d     = op_a;
            b_d     = op_b;
            acc_d   = '0;
            mctl_d  = {id_regwrite, id_memread, id_memwrite, id_memtoreg};
            mrd_d   = id_rd;
        end else if (id_valid) begin
            alu_d   = alu_res;
            store_d = store_val;
            rd_d    = id_rd;
            ctl_d   = {id_regwrite, id_memread, id_memwrite, id_memtoreg};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            a_q     <= '0;
            b_q     <= '0;
            acc_q   <= '0;
            mctl_q  <= '0;
            mrd_q   <= '0;
            alu_q   <= '0;
            store_q <= '0;
            rd_q    <= '0;
            ctl_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            acc_q   <= acc_d;
            mctl_q  <= mctl_d;
            mrd_q   <= mrd_d;
            alu_q   <= alu_d;
            store_q <= store_d;
            rd_q    <= rd_d;
            ctl_q   <= ctl_d;
        end
    end

    assign exmem_alu      = alu_q;
    assign exmem_store    = store_q;
    assign exmem_rd       = rd_q;
    assign exmem_regwrite = ctl_q[3];
    assign exmem_memread  = ctl_q[2];
    assign exmem_memwrite = ctl_q[1];
    assign exmem_memtoreg = ctl_q[0];

endmodule
